// File: rtl/qr_matrix_streamer_pkg.sv
// Shared types and helpers for the QR matrix streamer.
// Optional build macro: QRSTREAM_COLMAJOR_EN selects column-major read-out order.
package qr_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_N      = 3;
  localparam int unsigned ELEMS      = DEF_N * DEF_N;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_LEAD      = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  // Maps the k-th streamed element to its buffer address. Host writes are
  // always row-major, so row-major read-out is the identity mapping.
  function automatic int unsigned idx2addr(input int unsigned idx, input int unsigned n);
    int unsigned r;
    int unsigned c;
`ifdef QRSTREAM_COLMAJOR_EN
    c = idx / n;
    r = idx % n;
`else
    r = idx / n;
    c = idx % n;
`endif
    return r * n + c;
  endfunction

endpackage

// File: rtl/qr_matrix_streamer_if.sv
// Host write port of the QR matrix streamer (valid/ready element stream).
interface qr_matrix_streamer_if #(
  parameter int unsigned DATA_W = qr_pkg::DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/qr_matrix_streamer_elem_buf.sv
// Matrix element store: synchronous write port, registered read port that
// returns zero whenever no read is requested.
module qr_elem_buf #(
  parameter int unsigned DATA_W = qr_pkg::DEF_DATA_W,
  parameter int unsigned DEPTH  = qr_pkg::ELEMS,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Storage write; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read mux: selected element when reading, zero otherwise.
  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = '0;
    end
  end

  // Read data register drives the core's A port directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/qr_matrix_streamer.sv
// QR core transmit front end: buffers one N x N matrix from the host, then
// plays it out as start + LEAD idle cycles + one element per cycle, and holds
// off the next matrix until the core pulses done.
// Optional build macro: QRSTREAM_COLMAJOR_EN (column-major read-out order).
module qr_matrix_streamer
  import qr_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned N      = DEF_N,
  parameter int unsigned LEAD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  qr_matrix_streamer_if.slave  host,
  output logic                 start,
  output logic [DATA_W-1:0]    A,
  input  logic                 done,
  output logic                 busy
);

  localparam int unsigned NUM_ELEMS = N * N;
  localparam int unsigned CNT_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_ELEMS - 1);
  localparam logic [2:0]       LEAD_LAST = 3'(LEAD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [2:0]       lead_cnt_q, lead_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;

  logic             xfer_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [CNT_W-1:0] rd_idx_s;
  logic [CNT_W-1:0] rd_addr_s;

  // Next-state, counter and buffer-port decode.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    lead_cnt_d = lead_cnt_q;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    rd_idx_s   = '0;
    xfer_s     = host.in_valid & in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          wr_en_s  = 1'b1;
          wr_cnt_d = CNT_W'(1);
          state_d  = ST_LOAD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          wr_en_s = 1'b1;
          if (wr_cnt_q == LAST_IDX) begin
            lead_cnt_d = 3'd0;
            // With no lead time the first element is fetched on the same edge.
            if (LEAD == 0) begin
              state_d  = ST_STREAM;
              rd_en_s  = 1'b1;
              rd_cnt_d = '0;
            end else begin
              state_d  = ST_LEAD;
            end
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LEAD: begin
        if (lead_cnt_q == LEAD_LAST) begin
          state_d  = ST_STREAM;
          rd_en_s  = 1'b1;
          rd_cnt_d = '0;
        end else begin
          lead_cnt_d = lead_cnt_q + 3'd1;
        end
      end
      ST_STREAM: begin
        if (rd_cnt_q == LAST_IDX) begin
          state_d = ST_WAIT_DONE;
        end else begin
          rd_en_s  = 1'b1;
          rd_idx_s = rd_cnt_q + CNT_W'(1);
          rd_cnt_d = rd_idx_s;
        end
      end
      ST_WAIT_DONE: begin
        if (done) begin
          state_d    = ST_IDLE;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          lead_cnt_d = 3'd0;
        end else begin
          state_d    = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        lead_cnt_d = 3'd0;
      end
    endcase

    rd_addr_s  = CNT_W'(idx2addr(32'(rd_idx_s), N));
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    start_d    = (state_d == ST_LEAD) || (state_d == ST_STREAM) || (state_d == ST_WAIT_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, counters and registered handshake/control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      lead_cnt_q <= 3'd0;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      lead_cnt_q <= lead_cnt_d;
      in_ready_q <= in_ready_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  qr_elem_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_ELEMS),
    .AW     (CNT_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_addr (wr_cnt_q),
    .wr_data (host.in_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (A)
  );

  assign host.in_ready = in_ready_q;
  assign start         = start_q;
  assign busy          = busy_q;

endmodule

// File: doc/qr_matrix_streamer.md
Name: qr_matrix_streamer

Overview:
Transmit-side front end for the QR decomposition core. Accepts matrix elements from a host over a valid/ready write port and buffers one full N x N matrix. Drives the core's start/A serial stream: start, then LEAD idle cycles, then one element per cycle. Holds off the next matrix until the core reports done.

Parameters:
DATA_W, 16, element width (matches core A port)
N, 3, matrix dimension; buffer depth N*N
LEAD, 2, cycles from start rising to first element on A (0..7)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  host element valid
in_ready  output  1  block can accept an element this cycle
in_data  input  DATA_W  host element, row-major order (a11,a12,...,aNN)
start  output  1  start to QR core
A  output  DATA_W  serial element stream to QR core
done  input  1  QR core completion, single-cycle pulse
busy  output  1  high from first accepted element until done is consumed

Behaviour:
- Reset (sync, active-high): state=IDLE, wr_cnt=0, rd_cnt=0, lead_cnt=0. Outputs: in_ready=1, start=0, A=0, busy=0. Buffer contents are don't-care. Reset during any state aborts the current matrix; no partial stream resumes.
- States:
  - IDLE: in_ready=1. A transfer occurs on in_valid&in_ready; it writes buf[0] and goes to LOAD (wr_cnt=1).
  - LOAD: in_ready=1. Each transfer writes buf[wr_cnt] and increments wr_cnt. The transfer that writes index N*N-1 sets in_ready=0 next cycle and moves to LEAD.
  - LEAD: start=1 and A=0 for exactly LEAD cycles; then STREAM. LEAD=0 goes straight to STREAM.
  - STREAM: start=1, A=buf[rd_cnt], one element per cycle, rd_cnt 0..N*N-1 with no gaps. After the last element, go to WAIT_DONE.
  - WAIT_DONE: start=1, A=0. On done=1, next cycle is IDLE with start=0, busy=0, in_ready=1, counters cleared.
- Latency: the cycle after the last input transfer has start=1. Element k appears on A in cycle LEAD+k after start rises. A is registered.
- in_ready is registered and depends only on state. The host may hold in_valid high; back-pressure is lossless. in_data is ignored when in_valid=0.
- done outside WAIT_DONE is ignored and not latched.
- Counters are clog2(N*N) bits wide and never wrap. Saturation at N*N-1 is the terminal condition.
- busy=1 in LOAD, LEAD, STREAM and WAIT_DONE.

Optional Feature:
QRSTREAM_COLMAJOR_EN
- Defined: A emits column-major order, buf[r*N+c] with c outer and r inner (a11,a21,a31,a12,...). Host write order stays row-major. Implemented as a remapped read address; timing is unchanged.
- Undefined: A emits row-major, identical to host write order.

Decomposition:
- Shared package qr_pkg holds:
  - DATA_W and N defaults
  - localparam ELEMS=N*N
  - the state enum typedef (IDLE, LOAD, LEAD, STREAM, WAIT_DONE)
  - function idx2addr(rd_cnt) implementing the optional column-major remap
- One natural sub-module: qr_elem_buf, an ELEMS x DATA_W register file with a synchronous write port and a registered read port, used for the matrix store. The FSM and counters stay in the top.

Test Plan:
- Reset then idle: hold reset 5 cycles -> in_ready=1, start=0, A=0, busy=0. With in_valid=0 for 20 cycles, nothing changes.
- Identity-like stream, N=3, LEAD=2: write 2,0,0,0,2,0,0,0,2 back-to-back -> start rises the next cycle; A=0,0 during lead, then 2,0,0,0,2,0,0,0,2 on consecutive cycles; A=0 and start=1 until done; done pulse -> start=0, in_ready=1 the next cycle.
- Host gaps: write 1..9 with in_valid toggling every other cycle -> exactly 9 transfers captured; A stream is 1..9 with no gaps.
- Back-pressure: keep in_valid=1 with a 10th element (0xBEEF) during LEAD/STREAM/WAIT_DONE -> in_ready=0; 0xBEEF is accepted only after done and becomes buf[0] of the next matrix.
- Stray done and mid-run reset: pulse done in LOAD -> ignored, stream still occurs. Assert reset mid-STREAM -> next cycle start=0, A=0, IDLE; a fresh 9-element load streams correctly.
- With QRSTREAM_COLMAJOR_EN defined: write 1..9 -> A emits 1,4,7,2,5,8,3,6,9.
